instr_fetch_unit: RTL and testbench

//  Upstream fetch stage of the 8-bit RISC core. Owns the program counter and the instruction

---
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_unit                                             |
// | Description : Fetch stage of the 8-bit RISC core: PC, IR, memory request   |
// |               handshake and HLT/SKZ/JMP control-flow handling.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter int AW  = 5,
  parameter int DW  = 8,
  parameter int OPW = DW - 3
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           mem_req,
  output logic [AW-1:0]  mem_addr,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           mem_valid,
  output logic           instr_valid,
  output logic [2:0]     opcode,
  output logic [OPW-1:0] operand,
  output logic [AW-1:0]  pc,
  input  logic           exec_done,
  input  logic           acc_zero,
  output logic           halted,
  input  logic           resume
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [2:0] C_OP_HLT = 3'b000;
  localparam logic [2:0] C_OP_SKZ = 3'b001;
  localparam logic [2:0] C_OP_JMP = 3'b111;

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_pc, w_pc_next;
  logic [DW-1:0] r_ir, w_ir_next;
  logic          r_mem_req;
  logic          r_instr_valid;
  logic          r_halted;
  logic          w_accept;
  logic [AW-1:0] w_jmp_target;
  logic [AW-1:0] w_pc_inc;

  generate
    if (OPW >= AW) begin : g_jmp_trunc
      assign w_jmp_target = r_ir[AW-1:0];
    end else begin : g_jmp_zext
      assign w_jmp_target = {{(AW-OPW){1'b0}}, r_ir[OPW-1:0]};
    end
  endgenerate

  assign w_pc_inc = r_pc + AW'(1);
  // The request register qualifies acceptance, so valid before the first req edge is ignored.
  assign w_accept = (r_state == S_FETCH) && r_mem_req && mem_valid;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    case (r_state)
      S_FETCH: begin
        if (w_accept) begin
          w_ir_next    = mem_rdata;
          w_pc_next    = w_pc_inc;
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: w_state_next = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          w_state_next = S_FETCH;
          case (r_ir[DW-1:DW-3])
            C_OP_HLT: w_state_next = S_HALTED;
            C_OP_SKZ: if (acc_zero) w_pc_next = w_pc_inc;
            C_OP_JMP: w_pc_next = w_jmp_target;
            default:  w_pc_next = r_pc;
          endcase
        end
      end
      S_HALTED: if (resume) w_state_next = S_FETCH;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // Handshake outputs are derived from the next state so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_pc          <= '0;
      r_ir          <= '0;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_ir          <= w_ir_next;
      r_mem_req     <= (w_state_next == S_FETCH);
      r_instr_valid <= (w_state_next == S_DECODE);
      r_halted      <= (w_state_next == S_HALTED);
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_pc;
  assign pc          = r_pc;
  assign instr_valid = r_instr_valid;
  assign opcode      = r_ir[DW-1:DW-3];
  assign operand     = r_ir[OPW-1:0];
  assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_fetch_unit                                          |
// | Description : Self-checking bench for instr_fetch_unit with a decode       |
// |               scoreboard fed by the memory responder.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;
  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int OPW = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mem_req;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_rdata = '0;
  logic           mem_valid = 1'b0;
  logic           instr_valid;
  logic [2:0]     opcode;
  logic [OPW-1:0] operand;
  logic [AW-1:0]  pc;
  logic           exec_done = 1'b0;
  logic           acc_zero = 1'b0;
  logic           halted;
  logic           resume = 1'b0;

  typedef struct packed {
    logic [2:0]     op;
    logic [OPW-1:0] opd;
    logic [AW-1:0]  pc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  instr_fetch_unit #(.AW(AW), .DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .instr_valid(instr_valid),
    .opcode(opcode), .operand(operand), .pc(pc), .exec_done(exec_done),
    .acc_zero(acc_zero), .halted(halted), .resume(resume)
  );

  always #5 clk = ~clk;

  // Decoded-instruction consumer: every instr_valid pulse must match the oldest accepted fetch.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && instr_valid) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL decode_unexpected: instr_valid=1 with no fetch accepted (opcode=%b pc=%0d)", opcode, pc);
      end else begin
        e = sb_q.pop_front();
        if ({opcode, operand, pc} !== {e.op, e.opd, e.pc}) begin
          n_fail++;
          $display("FAIL decode_sb: got op=%b opd=%0d pc=%0d, expected op=%b opd=%0d pc=%0d",
                   opcode, operand, pc, e.op, e.opd, e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory responder: waits (bounded) for a request, answers after 'delay' cycles.
  task automatic mem_serve(input logic [DW-1:0] word, input int delay,
                           output logic [AW-1:0] addr_seen, output int req_cycles,
                           output logic ir_moved);
    int n;
    logic [DW-1:0] ir0;
    exp_t e;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    addr_seen  = mem_addr;
    req_cycles = 0;
    ir_moved   = 1'b0;
    ir0        = {opcode, operand};
    if (!mem_req) begin
      req_cycles = -1;
      return;
    end
    mem_rdata = 8'hA5;
    for (int i = 0; i < delay; i++) begin
      if (mem_req && mem_addr == addr_seen) req_cycles++;
      @(negedge clk);
      if ({opcode, operand} !== ir0) ir_moved = 1'b1;
    end
    if (mem_req && mem_addr == addr_seen) req_cycles++;
    mem_rdata = word;
    mem_valid = 1'b1;
    e.op  = word[DW-1:DW-3];
    e.opd = word[OPW-1:0];
    e.pc  = addr_seen + AW'(1);
    sb_q.push_back(e);
    @(negedge clk);
    mem_valid = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic exec_instr(input logic az);
    @(negedge clk);
    exec_done = 1'b1;
    acc_zero  = az;
    @(negedge clk);
    exec_done = 1'b0;
    acc_zero  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_req, instr_valid, halted, pc, opcode, operand} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b iv=%b halt=%b pc=%0d op=%b opd=%0d, expected all 0",
               mem_req, instr_valid, halted, pc, opcode, operand);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_req: mem_req=%b before first edge, expected 0", mem_req);
    end
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_first_req: mem_req=%b addr=%0d, expected 1 / 0", mem_req, mem_addr);
    end
  endtask

  task automatic test_zero_wait();
    logic [AW-1:0] a; int rc; logic mv;
    mem_serve(8'h45, 0, a, rc, mv);
    n_checks++;
    if (a !== 5'd0 || rc !== 1) begin
      n_fail++;
      $display("FAIL zw_fetch: addr=%0d req_cycles=%0d, expected 0 / 1", a, rc);
    end
    n_checks++;
    if (instr_valid !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_decode: instr_valid=%b mem_req=%b, expected 1 / 0", instr_valid, mem_req);
    end
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_exec: instr_valid=%b mem_req=%b, expected 0 / 0", instr_valid, mem_req);
    end
    exec_instr(1'b0);
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 5'd1) begin
      n_fail++;
      $display("FAIL zw_next_req: mem_req=%b addr=%0d, expected 1 / 1", mem_req, mem_addr);
    end
  endtask

  task automatic test_delayed_valid();
    logic [AW-1:0] a; int rc; logic mv;
    apply_reset();
    mem_serve(8'h45, 3, a, rc, mv);
    n_checks++;
    if (a !== 5'd0 || rc !== 4 || mv !== 1'b0) begin
      n_fail++;
      $display("FAIL dly_fetch: addr=%0d req_cycles=%0d ir_moved=%b, expected 0 / 4 / 0", a, rc, mv);
    end
    @(negedge clk);
    mem_rdata = 8'hFF;
    mem_valid = 1'b1;
    repeat (2) @(negedge clk);
    mem_valid = 1'b0;
    mem_rdata = '0;
    n_checks++;
    if (opcode !== 3'b010 || operand !== 5'd5 || pc !== 5'd1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL dly_stray_valid: op=%b opd=%0d pc=%0d req=%b, expected 010 / 5 / 1 / 0",
               opcode, operand, pc, mem_req);
    end
    exec_instr(1'b0);
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 5'd1) begin
      n_fail++;
      $display("FAIL dly_next_req: mem_req=%b addr=%0d, expected 1 / 1", mem_req, mem_addr);
    end
  endtask

  task automatic test_jmp();
    logic [AW-1:0] a; int rc; logic mv;
    mem_serve(8'hE9, 0, a, rc, mv);
    @(negedge clk);
    exec_instr(1'b0);
    n_checks++;
    if (a !== 5'd1 || pc !== 5'd9 || mem_req !== 1'b1 || mem_addr !== 5'd9) begin
      n_fail++;
      $display("FAIL jmp_target: fetch_addr=%0d pc=%0d req=%b addr=%0d, expected 1 / 9 / 1 / 9",
               a, pc, mem_req, mem_addr);
    end
  endtask

  task automatic test_skz();
    logic [AW-1:0] a; int rc; logic mv;
    logic az;
    for (int k = 0; k < 2; k++) begin
      az = (k == 0);
      mem_serve(8'hE2, 0, a, rc, mv);
      @(negedge clk);
      exec_instr(1'b0);
      mem_serve(8'h20, 0, a, rc, mv);
      @(negedge clk);
      exec_instr(az);
      n_checks++;
      if (a !== 5'd2 || mem_req !== 1'b1 || mem_addr !== (az ? 5'd4 : 5'd3)) begin
        n_fail++;
        $display("FAIL skz_acc%0d: skz_addr=%0d req=%b next_addr=%0d, expected 2 / 1 / %0d",
                 az, a, mem_req, mem_addr, az ? 4 : 3);
      end
    end
  endtask

  task automatic test_halt();
    logic [AW-1:0] a; int rc; logic mv;
    int bad;
    mem_serve(8'h00, 0, a, rc, mv);
    @(negedge clk);
    exec_instr(1'b0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      exec_done = (i == 2);
      mem_valid = (i == 4);
      mem_rdata = 8'hE1;
      if (halted !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 5'd4) bad++;
      @(negedge clk);
    end
    exec_done = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    n_checks++;
    if (a !== 5'd3 || bad !== 0) begin
      n_fail++;
      $display("FAIL halt_hold: hlt_addr=%0d bad_cycles=%0d, expected 3 / 0", a, bad);
    end
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 5'd4) begin
      n_fail++;
      $display("FAIL halt_resume: halted=%b req=%b addr=%0d, expected 0 / 1 / 4", halted, mem_req, mem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    mem_rdata = 8'h45;
    mem_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || pc !== 5'd0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: req=%b pc=%0d iv=%b, expected 0 / 0 / 0", mem_req, pc, instr_valid);
    end
    @(negedge clk);
    mem_valid = 1'b0;
    mem_rdata = '0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (opcode !== 3'b000 || operand !== 5'd0 || mem_req !== 1'b1 || mem_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_no_ir_load: op=%b opd=%0d req=%b addr=%0d, expected 000 / 0 / 1 / 0",
               opcode, operand, mem_req, mem_addr);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a; int rc; logic mv;
    mem_serve(8'hFF, 0, a, rc, mv);
    @(negedge clk);
    exec_instr(1'b0);
    mem_serve(8'h41, 0, a, rc, mv);
    n_checks++;
    if (a !== 5'd31 || pc !== 5'd0) begin
      n_fail++;
      $display("FAIL wrap_fetch: fetch_addr=%0d pc=%0d, expected 31 / 0", a, pc);
    end
    @(negedge clk);
    exec_instr(1'b0);
    mem_serve(8'hFF, 0, a, rc, mv);
    @(negedge clk);
    exec_instr(1'b0);
    mem_serve(8'h20, 0, a, rc, mv);
    @(negedge clk);
    exec_instr(1'b1);
    n_checks++;
    if (a !== 5'd31 || mem_req !== 1'b1 || mem_addr !== 5'd1) begin
      n_fail++;
      $display("FAIL wrap_skz: skz_addr=%0d req=%b next_addr=%0d, expected 31 / 1 / 1", a, mem_req, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_delayed_valid();
    test_jmp();
    test_skz();
    test_halt();
    test_reset_mid_fetch();
    test_wrap();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d fetches never decoded, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
